clock_timekeeper: RTL and testbench

- Time-of-day and alarm core for the VGA analog clock. Sits directly upstream of clockRenderer.
- Consumes the 1 Hz and buzzer-rate tick pulses from the clock_div instances, plus the debounced one-cycle pulses from the button_debounce instances.
- Produces the hours/minutes/seconds and alarm-time values the renderer draws, the alarm-enabled flag used for the bell symbol, and the buzzer drive.

---
 rtl/clock_pkg.sv | 12 +
 rtl/wrap_counter.sv | 34 +++
 rtl/clock_timekeeper.sv | 145 ++++++++++++++
 tb/tb_clock_timekeeper.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared widths and limits for the clock time base.
// Also holds the system clock rate used by clock_div.
package clock_pkg;

    localparam int SEC_W       = 6;
    localparam int HR_W        = 4;
    localparam int SEC_MAX     = 59;
    localparam int MIN_MAX     = 59;
    localparam int HR_MAX      = 11;
    localparam int CLK_FREQ_HZ = 31_500_000;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter advancing by inc*STEP per enabled edge.
// wrap flags that the sum reached the modulus this cycle.
module wrap_counter #(
    parameter int W    = 6,
    parameter int MOD  = 60,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [1:0]   inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W:0] sum;
    logic [W:0] nxt;

    // One-bit-wider sum, folded back into range with a single subtract
    always_comb begin
        sum  = {1'b0, value} + ((W+1)'(inc) * (W+1)'(STEP));
        wrap = en && (sum >= (W+1)'(MOD));
        nxt  = wrap ? (sum - (W+1)'(MOD)) : sum;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset_n)
            value <= '0;
        else if (en)
            value <= nxt[W-1:0];
    end

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day, alarm setting, alarm trigger and buzzer gating.
// Feeds the renderer with time values and the bell/buzzer state.
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int ALARM_SECS = 60,
    parameter int AL_STEP    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sec_tick,
    input  logic             buzz_tick,
    input  logic             sec_adj,
    input  logic             min_adj,
    input  logic             hrs_adj,
    input  logic             al_adj,
    input  logic             al_toggle,
    output logic [SEC_W-1:0] seconds,
    output logic [SEC_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic [SEC_W-1:0] al_minutes,
    output logic [HR_W-1:0]  al_hours,
    output logic             al_on,
    output logic             alarm,
    output logic             buzzer_out
);

    logic             sec_wrap;
    logic             min_wrap;
    logic             alm_wrap;
    logic             carry_s;
    logic             carry_m;
    logic [1:0]       min_inc;
    logic [1:0]       hr_inc;
    logic             match;
    logic             match_d;
    logic             trig;
    logic             tone;
    logic             beep_phase;
    logic [5:0]       snd_cnt;

    wrap_counter #(.W(SEC_W), .MOD(SEC_MAX + 1)) u_sec (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sec_tick | sec_adj),
        .inc     (2'd1),
        .value   (seconds),
        .wrap    (sec_wrap)
    );

    wrap_counter #(.W(SEC_W), .MOD(MIN_MAX + 1)) u_min (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .inc     (min_inc),
        .value   (minutes),
        .wrap    (min_wrap)
    );

    wrap_counter #(.W(HR_W), .MOD(HR_MAX + 1)) u_hr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .inc     (hr_inc),
        .value   (hours),
        .wrap    ()
    );

    wrap_counter #(.W(SEC_W), .MOD(MIN_MAX + 1), .STEP(AL_STEP)) u_almin (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (al_adj),
        .inc     (2'd1),
        .value   (al_minutes),
        .wrap    (alm_wrap)
    );

    wrap_counter #(.W(HR_W), .MOD(HR_MAX + 1)) u_alhr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (al_adj & alm_wrap),
        .inc     (2'd1),
        .value   (al_hours),
        .wrap    ()
    );

    // Carries ripple only from a tick-driven seconds wrap; toggle blocks trigger
    always_comb begin
        carry_s = sec_tick & sec_wrap;
        carry_m = carry_s & min_wrap;
        min_inc = {1'b0, carry_s} + {1'b0, min_adj};
        hr_inc  = {1'b0, carry_m} + {1'b0, hrs_adj};
        match   = (hours == al_hours) && (minutes == al_minutes) &&
                  (seconds == '0);
        trig    = al_on && match && !match_d && !al_toggle;
    end

    // Match history, tone square wave and 1 s beep cadence
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            match_d    <= 1'b0;
            tone       <= 1'b0;
            beep_phase <= 1'b0;
        end else begin
            match_d <= match;
            tone    <= tone ^ buzz_tick;
            if (trig && !alarm)
                beep_phase <= 1'b1;
            else if (sec_tick)
                beep_phase <= ~beep_phase;
        end
    end

    // Enable flag, sounding period and buzzer gate
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            al_on      <= 1'b0;
            alarm      <= 1'b0;
            snd_cnt    <= '0;
            buzzer_out <= 1'b0;
        end else begin
            if (al_toggle)
                al_on <= ~al_on;
            if (al_toggle && al_on) begin
                alarm      <= 1'b0;
                snd_cnt    <= '0;
                buzzer_out <= 1'b0;
            end else begin
                buzzer_out <= alarm & beep_phase & tone;
                if (trig && !alarm) begin
                    alarm   <= 1'b1;
                    snd_cnt <= '0;
                end else if (alarm && sec_tick) begin
                    if (snd_cnt == 6'(ALARM_SECS - 1)) begin
                        alarm   <= 1'b0;
                        snd_cnt <= '0;
                    end else begin
                        snd_cnt <= snd_cnt + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboarded directed bench for clock_timekeeper.
// A behavioural model predicts every cycle; directed checks add fixed values.
module tb_clock_timekeeper;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sec_tick, buzz_tick, sec_adj, min_adj, hrs_adj;
    logic       al_adj, al_toggle;
    logic [5:0] seconds, minutes, al_minutes;
    logic [3:0] hours, al_hours;
    logic       al_on, alarm, buzzer_out;

    clock_timekeeper #(.ALARM_SECS(60), .AL_STEP(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sec_tick   (sec_tick),
        .buzz_tick  (buzz_tick),
        .sec_adj    (sec_adj),
        .min_adj    (min_adj),
        .hrs_adj    (hrs_adj),
        .al_adj     (al_adj),
        .al_toggle  (al_toggle),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .al_minutes (al_minutes),
        .al_hours   (al_hours),
        .al_on      (al_on),
        .alarm      (alarm),
        .buzzer_out (buzzer_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [34:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    int ms, mm, mh, mam, mah, mcnt;
    bit mon, malm, mmd, mtone, mph, mbz;
    int dut_bz_hi, mod_bz_hi;

    function automatic logic [34:0] pack_model();
        return {6'(ms), 6'(mm), 4'(mh), 6'(mam), 4'(mah),
                mon, malm, mbz, 6'd0};
    endfunction

    function automatic logic [34:0] pack_dut();
        return {seconds, minutes, hours, al_minutes, al_hours,
                al_on, alarm, buzzer_out, 6'd0};
    endfunction

    task automatic pop_cmp(input logic [34:0] obs);
        exp_t e;
        e = q.pop_front();
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        exp_t e;
        e.tag = tag;
        e.v   = 35'(exp);
        q.push_back(e);
        pop_cmp(35'(obs));
    endtask

    task automatic model(input bit rn, st, bt, sa, ma, ha, aa, at);
        bit match, trig;
        int cs, cm, msum;
        bit nalm, nbz, nph;
        int ncnt;
        if (!rn) begin
            ms = 0; mm = 0; mh = 0; mam = 0; mah = 0; mcnt = 0;
            mon = 0; malm = 0; mmd = 0; mtone = 0; mph = 0; mbz = 0;
            return;
        end
        match = (mh == mah) && (mm == mam) && (ms == 0);
        trig  = mon && match && !mmd && !at;
        nalm = malm; ncnt = mcnt; nbz = mbz; nph = mph;
        if (at && mon) begin
            nalm = 0; ncnt = 0; nbz = 0;
        end else begin
            nbz = malm && mph && mtone;
            if (trig && !malm) begin
                nalm = 1; ncnt = 0;
            end else if (malm && st) begin
                if (mcnt + 1 == 60) begin
                    nalm = 0; ncnt = 0;
                end else ncnt = mcnt + 1;
            end
        end
        if (trig && !malm) nph = 1;
        else if (st) nph = !mph;
        malm = nalm; mcnt = ncnt; mbz = nbz; mph = nph;
        mmd   = match;
        mtone = mtone ^ bt;
        if (at) mon = !mon;
        cs = (st && ms == 59) ? 1 : 0;
        if (st || sa) ms = (ms + 1) % 60;
        msum = mm + cs + int'(ma);
        cm   = (cs == 1 && msum >= 60) ? 1 : 0;
        mm   = msum % 60;
        mh   = (mh + cm + int'(ha)) % 12;
        if (aa) begin
            mam = mam + 10;
            if (mam == 60) begin
                mam = 0;
                mah = (mah + 1) % 12;
            end
        end
    endtask

    task automatic step(input string tag, input bit rn, st, bt, sa, ma,
                        ha, aa, at);
        exp_t e;
        reset_n = rn; sec_tick = st; buzz_tick = bt; sec_adj = sa;
        min_adj = ma; hrs_adj = ha; al_adj = aa; al_toggle = at;
        model(rn, st, bt, sa, ma, ha, aa, at);
        e.tag = tag;
        e.v   = pack_model();
        q.push_back(e);
        @(posedge clk);
        #1;
        pop_cmp(pack_dut());
        if (buzzer_out) dut_bz_hi++;
        if (mbz) mod_bz_hi++;
        reset_n = 1'b1; sec_tick = 0; buzz_tick = 0; sec_adj = 0;
        min_adj = 0; hrs_adj = 0; al_adj = 0; al_toggle = 0;
    endtask

    task automatic idle(input string tag);
        step(tag, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick(input string tag);
        step(tag, 1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_time(input int th, input int tm, input int tsec);
        while (mh != th) step("set_h", 1, 0, 0, 0, 0, 1, 0, 0);
        while (mm != tm) step("set_m", 1, 0, 0, 0, 1, 0, 0, 0);
        while (ms != tsec) step("set_s", 1, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic chk_hms(input string tag, input int h, m, s);
        chk({tag, "_h"}, int'(hours), h);
        chk({tag, "_m"}, int'(minutes), m);
        chk({tag, "_s"}, int'(seconds), s);
    endtask

    initial begin
        reset_n = 0; sec_tick = 0; buzz_tick = 0; sec_adj = 0;
        min_adj = 0; hrs_adj = 0; al_adj = 0; al_toggle = 0;
        dut_bz_hi = 0; mod_bz_hi = 0;
        step("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_all", int'(pack_dut() != 0), 0);

        for (int i = 0; i < 3661; i++) tick("run");
        chk_hms("t3661", 1, 1, 1);

        set_time(11, 59, 59);
        tick("roll12");
        chk_hms("roll12", 0, 0, 0);

        set_time(0, 0, 59);
        step("sadj_wrap", 1, 0, 0, 1, 0, 0, 0, 0);
        chk_hms("sadj_wrap", 0, 0, 0);

        set_time(0, 59, 59);
        step("tick_madj", 1, 1, 0, 0, 1, 0, 0, 0);
        chk_hms("tick_madj", 1, 1, 0);

        step("rst2", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step("al_adj", 1, 0, 0, 0, 0, 0, 1, 0);
        chk("al6_h", int'(al_hours), 1);
        chk("al6_m", int'(al_minutes), 0);
        for (int i = 0; i < 66; i++)
            step("al_adj", 1, 0, 0, 0, 0, 0, 1, 0);
        chk("al72_h", int'(al_hours), 0);
        chk("al72_m", int'(al_minutes), 0);

        for (int i = 0; i < 6; i++)
            step("al_adj", 1, 0, 0, 0, 0, 0, 1, 0);
        step("al_en", 1, 0, 0, 0, 0, 0, 0, 1);
        chk("al_on", int'(al_on), 1);
        set_time(0, 59, 59);
        tick("hit");
        chk("hit_s", int'(seconds), 0);
        chk("hit_alarm_pre", int'(alarm), 0);
        idle("trig");
        chk("trig_alarm", int'(alarm), 1);

        for (int t = 0; t < 60; t++) begin
            for (int c = 0; c < 7; c++)
                step("sound", 1, 0, c[0], 0, 0, 0, 0, 0);
            if (t == 59) chk("alarm_before_last", int'(alarm), 1);
            tick("sound_tick");
        end
        chk("alarm_done", int'(alarm), 0);
        chk("buzz_hi_cnt", dut_bz_hi, mod_bz_hi);
        chk("buzz_seen", int'(mod_bz_hi > 0), 1);

        set_time(0, 59, 59);
        tick("hit2");
        idle("trig2");
        chk("trig2_alarm", int'(alarm), 1);
        for (int c = 0; c < 6; c++)
            step("snd2", 1, 0, 1, 0, 0, 0, 0, 0);
        step("tog_off", 1, 0, 0, 0, 0, 0, 0, 1);
        chk("tog_off_on", int'(al_on), 0);
        chk("tog_off_alarm", int'(alarm), 0);
        chk("tog_off_bz", int'(buzzer_out), 0);
        step("tog_on", 1, 0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 4; c++) idle("no_retrig");
        chk("no_retrig", int'(alarm), 0);
        chk_hms("still_1h", 1, 0, 0);

        set_time(0, 59, 59);
        tick("hit3");
        idle("trig3");
        chk("trig3_alarm", int'(alarm), 1);
        for (int c = 0; c < 5; c++)
            step("snd3", 1, 0, 1, 0, 0, 0, 0, 0);
        step("rst_mid", 0, 1, 1, 0, 0, 0, 0, 0);
        chk("rst_mid_all", int'(pack_dut() != 0), 0);
        idle("post_rst");
        chk("post_rst_s", int'(seconds), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
